// File: rtl/nn_ctrl_pkg.sv
// Shared control definitions for the layer sequencer and the weight/bias config loader.
package nn_ctrl_pkg;

  localparam int unsigned BURST_CNT_W = 16;

  typedef enum logic {
    SEQ_IDLE  = 1'b0,
    SEQ_SHIFT = 1'b1
  } seq_state_e;

  // LSB position of word k in a flat bus of w-bit words.
  function automatic int unsigned word_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/layer_stream_sequencer.sv
// Captures a parallel burst from layer L and replays it as a serial stream into layer L+1.
module layer_stream_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NN-1:0]            in_valid,
  input  logic [NN*dataWidth-1:0]  in_data,
  input  logic                     err_clr,
  output logic                     out_valid,
  output logic [dataWidth-1:0]     out_data,
  output logic                     busy,
  output logic                     layer_done,
  output logic                     overrun,
  output logic                     misalign,
  output logic [BURST_CNT_W-1:0]   burst_cnt
);

  localparam int CNT_W = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NN - 1);

  seq_state_e                 r_state;
  logic [CNT_W-1:0]           r_idx;
  logic [dataWidth-1:0]       r_buf [NN];
  logic                       r_out_valid;
  logic [dataWidth-1:0]       r_out_data;
  logic                       r_done;
  logic                       r_overrun;
  logic                       r_misalign;
  logic [BURST_CNT_W-1:0]     r_burst_cnt;

  logic [dataWidth-1:0]       w_in_word [NN];
  logic                       w_cap;
  logic                       w_partial;
  logic                       w_last;
  logic [CNT_W-1:0]           w_next_idx;

  for (genvar k = 0; k < NN; k++) begin : g_unpack
    assign w_in_word[k] = in_data[word_lsb(k, dataWidth) +: dataWidth];
  end

  assign w_cap      = &in_valid;
  assign w_partial  = (|in_valid) & ~w_cap;
  assign w_last     = (r_state == SEQ_SHIFT) && (r_idx == LAST_IDX);
  assign w_next_idx = r_idx + 1'b1;

  // out_data is registered one word ahead of r_idx so each word appears in the cycle its index is current.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SEQ_IDLE;
      r_idx       <= '0;
      r_buf       <= '{default: '0};
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_burst_cnt <= '0;
    end else if (r_state == SEQ_IDLE) begin
      if (w_cap) begin
        r_buf       <= w_in_word;
        r_idx       <= '0;
        r_state     <= SEQ_SHIFT;
        r_out_valid <= 1'b1;
        r_out_data  <= w_in_word[0];
      end
      r_done <= 1'b0;
    end else if (w_last) begin
      r_burst_cnt <= r_burst_cnt + 1'b1;
      r_done      <= 1'b0;
      r_idx       <= '0;
      if (w_cap) begin
        r_buf      <= w_in_word;
        r_out_data <= w_in_word[0];
      end else begin
        r_state     <= SEQ_IDLE;
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end
    end else begin
      r_idx      <= w_next_idx;
      r_out_data <= r_buf[w_next_idx];
      r_done     <= (w_next_idx == LAST_IDX);
    end
  end

  // Sticky error flags: a new error event takes priority over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      if ((r_state == SEQ_SHIFT) && !w_last && w_cap) r_overrun <= 1'b1;
      else if (err_clr)                                r_overrun <= 1'b0;
      if (w_partial)    r_misalign <= 1'b1;
      else if (err_clr) r_misalign <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = (r_state == SEQ_SHIFT);
  assign layer_done = r_done;
  assign overrun    = r_overrun;
  assign misalign   = r_misalign;
  assign burst_cnt  = r_burst_cnt;

endmodule

// File: tb/tb_layer_stream_sequencer.sv
// Scoreboard bench: NN=4 directed scenarios plus an NN=30 regression instance.
module tb_layer_stream_sequencer;

  typedef struct packed {
    logic [15:0] d;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   in_valid4 = '0;
  logic [63:0]  in_data4  = '0;
  logic         err_clr4  = 1'b0;
  logic         out_valid4, busy4, done4, overrun4, misalign4;
  logic [15:0]  out_data4, burst_cnt4;

  logic [29:0]  in_valid30 = '0;
  logic [479:0] in_data30  = '0;
  logic         err_clr30  = 1'b0;
  logic         out_valid30, busy30, done30, overrun30, misalign30;
  logic [15:0]  out_data30, burst_cnt30;

  exp_t q4[$];
  exp_t q30[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  layer_stream_sequencer #(.NN(4), .dataWidth(16)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_data(in_data4), .err_clr(err_clr4),
    .out_valid(out_valid4), .out_data(out_data4), .busy(busy4), .layer_done(done4),
    .overrun(overrun4), .misalign(misalign4), .burst_cnt(burst_cnt4)
  );

  layer_stream_sequencer #(.NN(30), .dataWidth(16)) dut30 (
    .clk(clk), .rst(rst), .in_valid(in_valid30), .in_data(in_data30), .err_clr(err_clr30),
    .out_valid(out_valid30), .out_data(out_data30), .busy(busy30), .layer_done(done30),
    .overrun(overrun30), .misalign(misalign30), .burst_cnt(burst_cnt30)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid4  = '0;
    in_valid30 = '0;
    err_clr4   = 1'b0;
    #1;
    q4.delete();
    q30.delete();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic cap4(input logic [63:0] d, input bit expect_it);
    in_valid4 = '1;
    in_data4  = d;
    if (expect_it)
      for (int k = 0; k < 4; k++) q4.push_back('{d: d[k*16 +: 16], last: (k == 3)});
  endtask

  task automatic burst30();
    for (int k = 0; k < 30; k++) begin
      in_data30[k*16 +: 16] = 16'($urandom);
      q30.push_back('{d: in_data30[k*16 +: 16], last: (k == 29)});
    end
    in_valid30 = '1;
    cyc();
    in_valid30 = '0;
    repeat (31) cyc();
  endtask

  // Monitors: pop and compare whenever a DUT presents a word.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid4) begin
      if (q4.size() == 0) chk("unexpected_word4", out_data4, 16'hDEAD);
      else begin
        e = q4.pop_front();
        chk("word4", out_data4, e.d);
        chk("layer_done4", done4, e.last);
      end
    end else begin
      chk("idle_data4", out_data4, 0);
      chk("idle_done4", done4, 0);
    end
    chk("busy_vs_valid4", busy4, out_valid4);
  end

  always @(negedge clk) begin
    exp_t e;
    if (out_valid30) begin
      if (q30.size() == 0) chk("unexpected_word30", out_data30, 16'hDEAD);
      else begin
        e = q30.pop_front();
        chk("word30", out_data30, e.d);
        chk("layer_done30", done30, e.last);
      end
    end else begin
      chk("idle_data30", out_data30, 0);
      chk("idle_done30", done30, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset state and a single burst
    do_reset();
    chk("rst_out_valid", out_valid4, 0);
    chk("rst_out_data", out_data4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_overrun", overrun4, 0);
    chk("rst_misalign", misalign4, 0);
    chk("rst_burst_cnt", burst_cnt4, 0);
    cap4(64'h0004_0003_0002_0001, 1);
    cyc();
    in_valid4 = '0;
    chk("t1_valid_T1", out_valid4, 1);
    repeat (3) cyc();
    chk("t1_cnt_before_end", burst_cnt4, 0);
    cyc();
    chk("t1_burst_cnt", burst_cnt4, 1);
    chk("t1_idle_after", out_valid4, 0);

    // 2: back-to-back capture on the last-word cycle
    do_reset();
    cap4(64'h1114_1113_1112_1111, 1);
    cyc();
    in_valid4 = '0;
    repeat (3) begin
      @(negedge clk) chk("b2b_valid", out_valid4, 1);
      cyc();
    end
    cap4(64'h2224_2223_2222_2221, 1);
    @(negedge clk) chk("b2b_valid", out_valid4, 1);
    cyc();
    in_valid4 = '0;
    repeat (4) begin
      @(negedge clk) chk("b2b_valid", out_valid4, 1);
      cyc();
    end
    @(negedge clk) chk("b2b_end_valid", out_valid4, 0);
    chk("b2b_burst_cnt", burst_cnt4, 2);
    chk("b2b_overrun", overrun4, 0);
    cyc();

    // 3: overrun, clear, and clear coincident with a fresh overrun
    do_reset();
    cap4(64'h0004_0003_0002_0001, 1);
    cyc();
    in_valid4 = '0;
    cyc();
    cap4(64'hBBBB_AAAA_9999_8888, 0);
    cyc();
    in_valid4 = '0;
    chk("ovr_set", overrun4, 1);
    repeat (3) cyc();
    chk("ovr_burst_cnt", burst_cnt4, 1);
    err_clr4 = 1'b1;
    cyc();
    err_clr4 = 1'b0;
    chk("ovr_cleared", overrun4, 0);
    cap4(64'h0004_0003_0002_0001, 1);
    cyc();
    in_valid4 = '0;
    cyc();
    cap4(64'hBBBB_AAAA_9999_8888, 0);
    err_clr4 = 1'b1;
    cyc();
    err_clr4  = 1'b0;
    in_valid4 = '0;
    chk("ovr_set_wins", overrun4, 1);
    chk("ovr_no_misalign", misalign4, 0);
    repeat (3) cyc();

    // 4: misaligned valid in IDLE and during SHIFT
    do_reset();
    in_valid4 = 4'b0101;
    in_data4  = 64'h5555_6666_7777_8888;
    cyc();
    in_valid4 = '0;
    chk("mis_set", misalign4, 1);
    repeat (3) begin
      chk("mis_no_capture", out_valid4, 0);
      cyc();
    end
    chk("mis_burst_cnt", burst_cnt4, 0);
    in_valid4 = 4'b0101;
    err_clr4  = 1'b1;
    cyc();
    in_valid4 = '0;
    chk("mis_set_wins", misalign4, 1);
    cyc();
    err_clr4 = 1'b0;
    chk("mis_cleared", misalign4, 0);
    cap4(64'h0D0C_0B0A_0908_0706, 1);
    cyc();
    in_valid4 = 4'b0011;
    cyc();
    in_valid4 = '0;
    chk("mis_in_shift", misalign4, 1);
    repeat (4) cyc();
    chk("mis_shift_cnt", burst_cnt4, 1);

    // 5: reset mid-burst, then clean replay
    do_reset();
    cap4(64'h0004_0003_0002_0001, 1);
    cyc();
    in_valid4 = '0;
    repeat (4) cyc();
    chk("rstm_pre_cnt", burst_cnt4, 1);
    cap4(64'h0004_0003_0002_0001, 1);
    cyc();
    in_valid4 = '0;
    cyc();
    rst = 1'b1;
    #1;
    chk("rstm_valid", out_valid4, 0);
    chk("rstm_busy", busy4, 0);
    chk("rstm_cnt", burst_cnt4, 0);
    chk("rstm_done", done4, 0);
    q4.delete();
    cyc();
    rst = 1'b0;
    cyc();
    cap4(64'hC0C4_C0C3_C0C2_C0C1, 1);
    cyc();
    in_valid4 = '0;
    repeat (5) cyc();
    chk("rstm_replay_cnt", burst_cnt4, 1);

    // 6: NN=30 regression and counter wrap
    for (int b = 0; b < 3; b++) burst30();
    chk("nn30_cnt", burst_cnt30, 3);
    force dut30.r_burst_cnt = 16'hFFFE;
    #1;
    release dut30.r_burst_cnt;
    cyc();
    chk("nn30_preload", burst_cnt30, 16'hFFFE);
    burst30();
    chk("nn30_cnt_ffff", burst_cnt30, 16'hFFFF);
    burst30();
    chk("nn30_cnt_wrap", burst_cnt30, 0);

    repeat (2) cyc();
    chk("q4_drained", q4.size(), 0);
    chk("q30_drained", q30.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
